// File: rtl/rmii_soc_detect_pkg.sv
// Shared POWERLINK/RMII constants, parser state encoding and the per-offset
// expected-byte lookup used by the SoC recogniser.
package rmii_soc_detect_pkg;

  localparam logic [47:0] SOC_MAC_DEF   = 48'h01111E000001;
  localparam logic [15:0] ETHERTYPE_DEF = 16'h88AB;
  localparam logic [7:0]  MSG_SOC_DEF   = 8'h01;
  localparam logic [7:0]  MN_NODE_DEF   = 8'hF0;

  localparam logic [1:0] DIBIT_ZERO = 2'b00;
  localparam logic [1:0] DIBIT_PRE  = 2'b01;
  localparam logic [1:0] DIBIT_SFD  = 2'b11;

  localparam logic [4:0] OFS_DA   = 5'd0;
  localparam logic [4:0] OFS_TYPE = 5'd12;
  localparam logic [4:0] OFS_MSG  = 5'd14;
  localparam logic [4:0] OFS_SRC  = 5'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

  typedef struct packed {
    logic       care;
    logic [7:0] val;
  } exp_byte_t;

  // Offsets not listed here (SA, EtherType-less bytes, byte 15) are don't-care.
  function automatic exp_byte_t expect_byte(input logic [4:0]  idx,
                                            input logic [47:0] mac,
                                            input logic [15:0] etype,
                                            input logic [7:0]  msg,
                                            input logic [7:0]  node,
                                            input logic        chk_src);
    exp_byte_t e;
    e = '{care: 1'b0, val: 8'h00};
    if (idx < OFS_DA + 5'd6)           e = '{1'b1, mac[8*(5-int'(idx)) +: 8]};
    else if (idx == OFS_TYPE)          e = '{1'b1, etype[15:8]};
    else if (idx == OFS_TYPE + 5'd1)   e = '{1'b1, etype[7:0]};
    else if (idx == OFS_MSG)           e = '{1'b1, msg};
    else if (idx == OFS_SRC)           e = '{chk_src, node};
    return e;
  endfunction

endpackage

// File: rtl/rmii_soc_detect_dibit_asm.sv
// Dibit-to-byte assembler: the byte is presented combinationally on the edge
// that samples its last dibit so the compare lands on that same edge.
module rmii_dibit_asm
  import rmii_soc_detect_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] rx,
  output logic [7:0] data,
  output logic       data_vld
);

  logic [5:0] sh;
  logic [1:0] phase;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh    <= '0;
      phase <= '0;
    end else if (en) begin
      sh    <= {rx, sh[5:2]};
      phase <= phase + 2'd1;
    end
  end

  assign data     = {rx, sh};
  assign data_vld = en && (phase == 2'd3);

endmodule

// File: rtl/rmii_soc_detect.sv
// RMII receive parser: preamble/SFD hunt, byte-wise POWERLINK SoC match and a
// fixed 68-clock SFD-to-SoC pulse used as the jitter controller's reference.
module rmii_soc_detect
  import rmii_soc_detect_pkg::*;
#(
  parameter logic [47:0] SOC_MAC       = SOC_MAC_DEF,
  parameter logic [15:0] ETHERTYPE     = ETHERTYPE_DEF,
  parameter logic [7:0]  MSG_SOC       = MSG_SOC_DEF,
  parameter logic [7:0]  MN_NODE       = MN_NODE_DEF,
  parameter bit          CHECK_SRC     = 1'b1,
  parameter int          MIN_PREAMBLE  = 8,
  parameter int          COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rm_crs_dv,
  input  logic [1:0]               rm_rx_data,
  output logic                     rx_active,
  output logic                     sfd_pulse,
  output logic                     soc_det,
  output logic                     frame_err,
  output logic [COUNTER_WIDTH-1:0] soc_cnt
);

  localparam logic [7:0] MIN_PRE = 8'(MIN_PREAMBLE);

  state_t     state;
  logic       crs_prev;
  logic       hold;
  logic [7:0] pre_cnt;
  logic [4:0] byte_idx;
  logic [7:0] data;
  logic       data_vld;
  logic       carrier_end;
  logic       sfd_hit;
  logic       byte_ok;
  exp_byte_t  exp;

  // crs_dv toggles once per nibble at end of frame, so only two lows in a row end it.
  assign carrier_end = !rm_crs_dv && !crs_prev;
  assign sfd_hit     = (state == ST_PRE) && (rm_rx_data == DIBIT_SFD) && (pre_cnt >= MIN_PRE);
  assign exp         = expect_byte(byte_idx, SOC_MAC, ETHERTYPE, MSG_SOC, MN_NODE, CHECK_SRC);
  assign byte_ok     = !exp.care || (data == exp.val);

  rmii_dibit_asm u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (sfd_hit),
    .en       (state == ST_DATA),
    .rx       (rm_rx_data),
    .data     (data),
    .data_vld (data_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      crs_prev  <= 1'b1;
      hold      <= 1'b1;
      pre_cnt   <= '0;
      byte_idx  <= '0;
      rx_active <= 1'b0;
      sfd_pulse <= 1'b0;
      soc_det   <= 1'b0;
      frame_err <= 1'b0;
      soc_cnt   <= '0;
    end else begin
      crs_prev  <= rm_crs_dv;
      sfd_pulse <= 1'b0;
      soc_det   <= 1'b0;
      frame_err <= 1'b0;
      if (carrier_end) hold <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // After reset we may be mid-frame: skip it until the carrier has ended once.
          if (rm_crs_dv) begin
            if (hold) begin
              state     <= ST_DROP;
              rx_active <= 1'b1;
            end else if (rm_rx_data == DIBIT_PRE || rm_rx_data == DIBIT_ZERO) begin
              state     <= ST_PRE;
              rx_active <= 1'b1;
              pre_cnt   <= (rm_rx_data == DIBIT_PRE) ? 8'd1 : 8'd0;
            end
          end
        end
        ST_PRE: begin
          if (carrier_end) begin
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end else if (rm_rx_data == DIBIT_PRE) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if (rm_rx_data == DIBIT_ZERO && pre_cnt == 8'd0) begin
          end else if (sfd_hit) begin
            state     <= ST_DATA;
            sfd_pulse <= 1'b1;
            byte_idx  <= '0;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          // Byte 16 completing beats a simultaneous carrier end.
          if (data_vld && byte_idx == OFS_SRC) begin
            soc_det   <= byte_ok;
            if (byte_ok) soc_cnt <= soc_cnt + COUNTER_WIDTH'(1);
            state     <= carrier_end ? ST_IDLE : ST_DROP;
            rx_active <= !carrier_end;
          end else if (carrier_end) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end else if (data_vld) begin
            if (byte_ok) byte_idx <= byte_idx + 5'd1;
            else         state    <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (carrier_end) begin
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_soc_detect.sv
// Frame-level bench: each segment is analysed as a whole (preamble run, SFD
// index, byte values, carrier-end index) to predict every output per clock.
module tb_rmii_soc_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crs_dv = 1'b0;
  logic [1:0]  rx_data = 2'b00;

  logic        rx_active, sfd_pulse, soc_det, frame_err;
  logic [31:0] soc_cnt;
  logic        rx_active_b, sfd_pulse_b, soc_det_b, frame_err_b;
  logic [3:0]  soc_cnt_b;

  rmii_soc_detect dut (
    .clk(clk), .rst(rst), .rm_crs_dv(crs_dv), .rm_rx_data(rx_data),
    .rx_active(rx_active), .sfd_pulse(sfd_pulse), .soc_det(soc_det),
    .frame_err(frame_err), .soc_cnt(soc_cnt)
  );

  rmii_soc_detect #(.CHECK_SRC(1'b0), .COUNTER_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .rm_crs_dv(crs_dv), .rm_rx_data(rx_data),
    .rx_active(rx_active_b), .sfd_pulse(sfd_pulse_b), .soc_det(soc_det_b),
    .frame_err(frame_err_b), .soc_cnt(soc_cnt_b)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        act, sfd, soc1, soc0, err;
    logic [31:0] cnt1;
    logic [3:0]  cnt0;
  } exp_t;

  int          checks = 0, errors = 0;
  exp_t        exp_next, e;
  bit          exp_vld = 0, v;
  logic [31:0] m_cnt1 = 0;
  logic [3:0]  m_cnt0 = 0;
  bit          q_crs[$];
  logic [1:0]  q_rx[$];
  logic [7:0]  fb[32];
  int          sel_list[9] = '{0, 1, 2, 3, 4, 5, 12, 13, 14};
  int          last_sfd, last_soc;
  int          cyc = 0, sfd_cyc = 0, lat = -1;
  int          sfd_n = 0, soc_n = 0, soc_b_n = 0, err_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, ex);
    end
  endtask

  // Required byte at frame offset k, or -1 for don't-care.
  function automatic int exp_byte(input int k, input bit chk_src);
    case (k)
      0: return 8'h01;  1: return 8'h11;  2: return 8'h1E;
      3: return 8'h00;  4: return 8'h00;  5: return 8'h01;
      12: return 8'h88; 13: return 8'hAB; 14: return 8'h01;
      16: return chk_src ? 8'hF0 : -1;
      default: return -1;
    endcase
  endfunction

  // Predicted event indices (-1 = none) for the queued segment; output after edge i.
  task automatic model(input bit chk_src, output int p, output int c,
                       output int sfd_i, output int soc_i, output int err_i);
    int n, j, ones, t, eb;
    logic [7:0] b;
    n = q_crs.size();
    p = -1; c = n; sfd_i = -1; soc_i = -1; err_i = -1;
    for (int i = 0; i < n; i++)
      if (q_crs[i] && q_rx[i] <= 2'b01) begin p = i; break; end
    if (p < 0) return;
    for (int i = p + 2; i < n; i++)
      if (!q_crs[i] && !q_crs[i-1]) begin c = i; break; end
    ones = (q_rx[p] == 2'b01) ? 1 : 0;
    j = p + 1;
    while (j < n && (q_rx[j] == 2'b01 || (q_rx[j] == 2'b00 && ones == 0))) begin
      if (q_rx[j] == 2'b01) ones++;
      j++;
    end
    if (j >= c || q_rx[j] != 2'b11 || ones < 8) return;
    sfd_i = j;
    for (int k = 0; k <= 16; k++) begin
      t = j + 4*k + 4;
      if ((k < 16) ? (c <= t) : (c < t)) begin err_i = c; return; end
      if (t >= n) return;
      b = {q_rx[t], q_rx[t-1], q_rx[t-2], q_rx[t-3]};
      eb = exp_byte(k, chk_src);
      if (eb >= 0 && b != eb[7:0]) return;
      if (k == 16) soc_i = t;
    end
  endtask

  task automatic drive_one(input bit c, input logic [1:0] r, input bit rs, input bit act,
                           input bit sf, input bit s1, input bit s0, input bit er);
    @(negedge clk);
    crs_dv = c; rx_data = r; rst = rs;
    if (rs) begin
      m_cnt1 = 0; m_cnt0 = 0;
    end else begin
      if (s1) m_cnt1 = m_cnt1 + 1;
      if (s0) m_cnt0 = m_cnt0 + 1;
    end
    exp_next = '{act, sf, s1, s0, er, m_cnt1, m_cnt0};
    exp_vld = 1;
  endtask

  task automatic run_segment(input int limit);
    int p, c, sf1, so1, er1, p0, c0, sf0, so0, er0;
    model(1'b1, p, c, sf1, so1, er1);
    model(1'b0, p0, c0, sf0, so0, er0);
    last_sfd = sf1; last_soc = so1;
    for (int i = 0; i < q_crs.size() && i < limit; i++)
      drive_one(q_crs[i], q_rx[i], 1'b0, p >= 0 && i >= p && i < c,
                i == sf1, i == so1, i == so0, i == er1);
    q_crs.delete(); q_rx.delete();
  endtask

  task automatic push(input bit c, input logic [1:0] r);
    q_crs.push_back(c); q_rx.push_back(r);
  endtask

  task automatic build(input int nz, input int npre, input logic [1:0] sfd,
                       input int nb, input int gap);
    int dn;
    logic [7:0] b;
    dn = 0;
    for (int i = 0; i < nz; i++) push(1'b1, 2'b00);
    for (int i = 0; i < npre; i++) push(1'b1, 2'b01);
    push(1'b1, sfd);
    for (int k = 0; k < nb; k++) begin
      b = fb[k];
      for (int d = 0; d < 4; d++) begin
        push(!(gap > 0 && (dn % gap) == gap - 1), b[2*d +: 2]);
        dn++;
      end
    end
    for (int i = 0; i < 3; i++) push(1'b0, 2'b00);
  endtask

  task automatic set_soc();
    for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
    fb[0] = 8'h01; fb[1] = 8'h11; fb[2] = 8'h1E; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    fb[12] = 8'h88; fb[13] = 8'hAB; fb[14] = 8'h01; fb[15] = 8'hFF; fb[16] = 8'hF0;
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  // Per-cycle compare against the frame-level prediction.
  always begin
    @(posedge clk);
    e = exp_next; v = exp_vld;
    #1;
    if (v) begin
      chk("rx_active", rx_active, e.act);
      chk("sfd_pulse", sfd_pulse, e.sfd);
      chk("soc_det", soc_det, e.soc1);
      chk("frame_err", frame_err, e.err);
      chk("soc_cnt", soc_cnt, e.cnt1);
      chk("rx_active_b", rx_active_b, e.act);
      chk("sfd_pulse_b", sfd_pulse_b, e.sfd);
      chk("soc_det_b", soc_det_b, e.soc0);
      chk("frame_err_b", frame_err_b, e.err);
      chk("soc_cnt_b", soc_cnt_b, e.cnt0);
    end
  end

  always begin
    @(posedge clk); #1;
    cyc++;
    if (sfd_pulse) begin sfd_n++; sfd_cyc = cyc; end
    if (soc_det) begin soc_n++; lat = cyc - sfd_cyc; end
    if (soc_det_b) soc_b_n++;
    if (frame_err) err_n++;
  end

  initial begin
    int s0, e0, b0, idx, kind, npre, nz, nb, gap;
    logic [1:0] sfd;

    for (int i = 0; i < 3; i++) drive_one(1'b0, 2'b00, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_one(1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);

    // Short preamble: 7 x 01 is one too few.
    set_soc(); build(0, 7, 2'b11, 21, 0); run_segment(1 << 30); settle();
    chk("short_pre_sfd", sfd_n, 0);
    chk("short_pre_cnt", soc_cnt, 0);

    // Reference SoC after a 31-dibit preamble.
    set_soc(); fb[15] = 8'hFF; build(0, 31, 2'b11, 21, 0); run_segment(1 << 30); settle();
    chk("ref_cnt", soc_cnt, 1);
    chk("ref_latency", lat, 68);
    chk("model_latency", last_soc - last_sfd, 68);

    // Wrong MessageType / EtherType: dropped silently.
    s0 = soc_n; e0 = err_n;
    set_soc(); fb[14] = 8'h03; build(0, 31, 2'b11, 21, 0); run_segment(1 << 30);
    set_soc(); fb[12] = 8'h08; fb[13] = 8'h00; build(0, 31, 2'b11, 21, 0); run_segment(1 << 30);
    settle();
    chk("pkt_type_soc", soc_n - s0, 0);
    chk("pkt_type_err", err_n - e0, 0);

    // Truncated after byte 10.
    s0 = soc_n; e0 = err_n;
    set_soc(); build(0, 20, 2'b11, 11, 0); run_segment(1 << 30); settle();
    chk("trunc_err", err_n - e0, 1);
    chk("trunc_soc", soc_n - s0, 0);

    // Single-cycle crs_dv gaps every 4 clocks.
    lat = -1;
    set_soc(); build(0, 12, 2'b11, 21, 4); run_segment(1 << 30); settle();
    chk("gap_latency", lat, 68);

    // Foreign source node: only the CHECK_SRC=0 instance fires.
    s0 = soc_n; b0 = soc_b_n;
    set_soc(); fb[16] = 8'h05; build(0, 12, 2'b11, 21, 0); run_segment(1 << 30); settle();
    chk("src_chk1", soc_n - s0, 0);
    chk("src_chk0", soc_b_n - b0, 1);

    // Carrier end on the same edge as byte 16 completion.
    s0 = soc_n; e0 = err_n;
    set_soc(); build(0, 10, 2'b11, 17, 0);
    q_crs[77] = 1'b0; q_crs[78] = 1'b0;
    run_segment(1 << 30); settle();
    chk("simul_soc", soc_n - s0, 1);
    chk("simul_err", err_n - e0, 0);

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 7);
      npre = $urandom_range(8, 24);
      nz   = $urandom_range(0, 2);
      nb   = $urandom_range(17, 22);
      sfd  = 2'b11;
      gap  = 0;
      set_soc();
      case (kind)
        3: begin
          idx = sel_list[$urandom_range(0, 8)];
          fb[idx] = fb[idx] ^ (8'd1 << $urandom_range(0, 7));
        end
        4: fb[16] = 8'($urandom);
        5: nb = $urandom_range(0, 16);
        6: begin npre = $urandom_range(0, 10); sfd = 2'($urandom_range(0, 3)); end
        7: gap = $urandom_range(2, 6);
        default: ;
      endcase
      build(nz, npre, sfd, nb, gap);
      run_segment(1 << 30);
    end

    // Reset in the middle of a frame, then 17 back-to-back SoCs.
    set_soc(); build(0, 15, 2'b11, 21, 0); run_segment(40);
    for (int i = 0; i < 2; i++) drive_one(1'b1, 2'($urandom), 1'b1, 0, 0, 0, 0, 0);
    s0 = soc_n;
    for (int i = 0; i < 20; i++) drive_one(1'b1, 2'($urandom), 1'b0, 1, 0, 0, 0, 0);
    drive_one(1'b0, 2'b00, 1'b0, 1, 0, 0, 0, 0);
    drive_one(1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    drive_one(1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_mid_soc", soc_n - s0, 0);
    chk("rst_mid_cnt", soc_cnt, 0);
    for (int i = 0; i < 17; i++) begin
      set_soc(); build(0, 8, 2'b11, 17, 0); run_segment(1 << 30);
    end
    settle();
    chk("wrap_cnt32", soc_cnt, 17);
    chk("wrap_cnt4", soc_cnt_b, 1);

    @(negedge clk); exp_vld = 0;
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
